servile_sram_wb_bridge: RTL and testbench

Byte-wide SRAM-port responder backed by a 32-bit Wishbone memory. It accepts the 8-bit SRAM-style write/read requests that the servile RF/memory arbiter issues, and turns each one into a single-word Wishbone initiator cycle. This lets the shared RF/data store live in an external or wider 32-bit memory instead of a dedicated byte SRAM. Optionally, it keeps the last-read word so that sequential byte reads complete at native SRAM speed.

---
 rtl/servile_sram_wb_bridge.sv | 194 +++++++++++++++++++
 tb/tb_servile_sram_wb_bridge.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servile_sram_wb_bridge.sv
// servile_sram_wb_bridge: byte-wide SRAM-port responder backed by a 32-bit
// Wishbone memory. Every byte write or read becomes one single-word Wishbone
// cycle. A write and a read requested together run as two cycles, write first.
//
// Build option: define SERVILE_SRAM_WB_RDCACHE_EN to keep the last word read.
// Sequential byte reads that fall inside that word are then answered from the
// cache at native SRAM speed. Writes to the cached word update it in place.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | o_sram_rdy high, requests sampled, cache hits served here
// WRITE | Wishbone write of one byte lane in flight, waiting for ack
// READ  | Wishbone word read in flight (or about to launch after a write)

module servile_sram_wb_bridge #(
   parameter int aw = 8
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [aw-1:0] i_sram_waddr,
   input  logic [7:0]    i_sram_wdata,
   input  logic          i_sram_wen,
   input  logic [aw-1:0] i_sram_raddr,
   input  logic          i_sram_ren,
   output logic [7:0]    o_sram_rdata,
   output logic          o_sram_rdy,
   output logic [aw-3:0] o_wb_adr,
   output logic [31:0]   o_wb_dat,
   output logic [3:0]    o_wb_sel,
   output logic          o_wb_we,
   output logic          o_wb_stb,
   input  logic [31:0]   i_wb_rdt,
   input  logic          i_wb_ack
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic [aw-1:0] r_raddr;
   logic          r_rd_pend;
   logic [7:0]    r_rdata;
   logic          r_wb_stb;
   logic          r_wb_we;
   logic [aw-3:0] r_wb_adr;
   logic [3:0]    r_wb_sel;
   logic [31:0]   r_wb_dat;

   logic          w_ack;
   logic          w_hit;
   logic [7:0]    w_hit_byte;

   function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
      case (lane)
         2'd0:    lane_byte = word[7:0];
         2'd1:    lane_byte = word[15:8];
         2'd2:    lane_byte = word[23:16];
         default: lane_byte = word[31:24];
      endcase
   endfunction

   // An ack only counts while our strobe is up; stray acks are ignored.
   assign w_ack = i_wb_ack & r_wb_stb;

`ifdef SERVILE_SRAM_WB_RDCACHE_EN
   logic          r_c_valid;
   logic [aw-3:0] r_c_tag;
   logic [31:0]   r_c_data;

   assign w_hit      = r_c_valid && (r_c_tag == i_sram_raddr[aw-1:2]);
   assign w_hit_byte = lane_byte(r_c_data, i_sram_raddr[1:0]);

   // Cache fill on read ack; write-through of the lane on a matching write ack.
   // The Wishbone output registers still hold the address/lane/data of the
   // cycle being acked, so they serve as the update source.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_c_valid <= 1'b0;
         r_c_tag   <= '0;
         r_c_data  <= '0;
      end else if (w_ack && (r_state == READ)) begin
         r_c_valid <= 1'b1;
         r_c_tag   <= r_wb_adr;
         r_c_data  <= i_wb_rdt;
      end else if (w_ack && (r_state == WRITE) && r_c_valid && (r_c_tag == r_wb_adr)) begin
         for (int i = 0; i < 4; i++) begin
            if (r_wb_sel[i]) r_c_data[8*i +: 8] <= r_wb_dat[8*i +: 8];
         end
      end
   end
`else
   assign w_hit      = 1'b0;
   assign w_hit_byte = 8'h00;
`endif

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state decode; a pending read follows the write directly.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (i_sram_wen)                w_state_nxt = WRITE;
            else if (i_sram_ren && !w_hit) w_state_nxt = READ;
         end
         WRITE: begin
            if (w_ack) w_state_nxt = r_rd_pend ? READ : IDLE;
         end
         READ: begin
            if (w_ack) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Request capture, registered Wishbone outputs and read-data return.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_raddr   <= '0;
         r_rd_pend <= 1'b0;
         r_rdata   <= 8'h00;
         r_wb_stb  <= 1'b0;
         r_wb_we   <= 1'b0;
         r_wb_adr  <= '0;
         r_wb_sel  <= 4'h0;
         r_wb_dat  <= 32'h0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_sram_wen) begin
                  r_rd_pend <= i_sram_ren;
                  if (i_sram_ren) r_raddr <= i_sram_raddr;
                  r_wb_stb  <= 1'b1;
                  r_wb_we   <= 1'b1;
                  r_wb_adr  <= i_sram_waddr[aw-1:2];
                  r_wb_sel  <= 4'b0001 << i_sram_waddr[1:0];
                  r_wb_dat  <= {4{i_sram_wdata}};
               end else if (i_sram_ren) begin
                  if (w_hit) begin
                     r_rdata <= w_hit_byte;
                  end else begin
                     r_raddr  <= i_sram_raddr;
                     r_wb_stb <= 1'b1;
                     r_wb_we  <= 1'b0;
                     r_wb_adr <= i_sram_raddr[aw-1:2];
                     r_wb_sel <= 4'hF;
                  end
               end
            end
            WRITE: begin
               if (w_ack) begin
                  r_wb_stb <= 1'b0;
                  r_wb_we  <= 1'b0;
               end
            end
            READ: begin
               // Strobe low here only when arriving from a write: launch the
               // deferred read after one idle cycle.
               if (!r_wb_stb) begin
                  r_rd_pend <= 1'b0;
                  r_wb_stb  <= 1'b1;
                  r_wb_we   <= 1'b0;
                  r_wb_adr  <= r_raddr[aw-1:2];
                  r_wb_sel  <= 4'hF;
               end else if (w_ack) begin
                  r_wb_stb <= 1'b0;
                  r_rdata  <= lane_byte(i_wb_rdt, r_raddr[1:0]);
               end
            end
            default: begin
               r_wb_stb <= 1'b0;
            end
         endcase
      end
   end

   assign o_sram_rdy   = (r_state == IDLE);
   assign o_sram_rdata = r_rdata;
   assign o_wb_stb     = r_wb_stb;
   assign o_wb_we      = r_wb_we;
   assign o_wb_adr     = r_wb_adr;
   assign o_wb_sel     = r_wb_sel;
   assign o_wb_dat     = r_wb_dat;

endmodule

// File: tb/tb_servile_sram_wb_bridge.sv
// Bench for servile_sram_wb_bridge: a Wishbone memory responder with
// programmable ack latency, a reference memory plus read-cache tag model, and
// queues of expected Wishbone cycles and read bytes.

module tb_servile_sram_wb_bridge;

`ifdef SERVILE_SRAM_WB_RDCACHE_EN
   localparam bit CACHE_EN = 1'b1;
`else
   localparam bit CACHE_EN = 1'b0;
`endif

   typedef struct packed {
      logic [5:0]  adr;
      logic [3:0]  sel;
      logic        we;
      logic [31:0] dat;
   } wb_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  waddr, wdata, raddr;
   logic        wen, ren;
   logic [7:0]  sram_rdata;
   logic        sram_rdy;
   logic [5:0]  wb_adr;
   logic [31:0] wb_dat;
   logic [3:0]  wb_sel;
   logic        wb_we, wb_stb;
   logic [31:0] wb_rdt;
   logic        wb_ack, ack_force, wb_ack_in;

   int          ntests = 0;
   int          nfail  = 0;
   int          ack_lat = 0;
   int          cnt = 0;

   logic [31:0] mem     [64];
   logic [31:0] ref_mem [64];
   logic        c_valid;
   logic [5:0]  c_tag;

   wb_t         exp_wb[$];
   wb_t         obs_wb[$];
   logic [7:0]  exp_rd[$];

   assign wb_ack_in = wb_ack | ack_force;

   always #5 clk = ~clk;

   servile_sram_wb_bridge #(.aw(8)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_sram_waddr (waddr),
      .i_sram_wdata (wdata),
      .i_sram_wen   (wen),
      .i_sram_raddr (raddr),
      .i_sram_ren   (ren),
      .o_sram_rdata (sram_rdata),
      .o_sram_rdy   (sram_rdy),
      .o_wb_adr     (wb_adr),
      .o_wb_dat     (wb_dat),
      .o_wb_sel     (wb_sel),
      .o_wb_we      (wb_we),
      .o_wb_stb     (wb_stb),
      .i_wb_rdt     (wb_rdt),
      .i_wb_ack     (wb_ack_in)
   );

   // Wishbone memory: acks after ack_lat cycles of strobe, logs each cycle.
   always begin
      @(posedge clk);
      #1;
      if (rst) begin
         wb_ack = 1'b0;
         cnt    = 0;
      end else if (wb_stb && !wb_ack) begin
         if (cnt >= ack_lat) begin
            if (wb_we) begin
               for (int i = 0; i < 4; i++)
                  if (wb_sel[i]) mem[wb_adr][8*i +: 8] = wb_dat[8*i +: 8];
            end
            wb_rdt = mem[wb_adr];
            wb_ack = 1'b1;
            cnt    = 0;
            obs_wb.push_back({wb_adr, wb_sel, wb_we, wb_dat});
         end else begin
            cnt++;
         end
      end else begin
         wb_ack = 1'b0;
         cnt    = 0;
      end
   end

   // Reference model: queues the expected Wishbone cycles and read byte, returns expected busy cycles.
   task automatic model_req(input logic w, input logic [7:0] wa, input logic [7:0] wd,
                            input logic r, input logic [7:0] ra, output int exp_cyc);
      wb_t        e;
      logic [3:0] s;
      exp_cyc = 0;
      if (w) begin
         s     = 4'b0001 << wa[1:0];
         e.adr = wa[7:2]; e.sel = s; e.we = 1'b1; e.dat = {4{wd}};
         exp_wb.push_back(e);
         ref_mem[wa[7:2]][8*wa[1:0] +: 8] = wd;
         exp_cyc += ack_lat + 1;
      end
      if (r) begin
         if (!(!w && CACHE_EN && c_valid && c_tag == ra[7:2])) begin
            e.adr = ra[7:2]; e.sel = 4'hF; e.we = 1'b0; e.dat = 32'h0;
            exp_wb.push_back(e);
            c_valid = 1'b1;
            c_tag   = ra[7:2];
            exp_cyc += ack_lat + 1 + (w ? 1 : 0);
         end
         exp_rd.push_back(ref_mem[ra[7:2]][8*ra[1:0] +: 8]);
      end
   endtask

   // Issue one request at the cycle after the current one and wait (bounded) for rdy.
   task automatic run_req(input logic w, input logic [7:0] wa, input logic [7:0] wd,
                          input logic r, input logic [7:0] ra,
                          output int cyc, output logic rdy0, output logic stb0,
                          output logic stb_end, output logic [7:0] rd);
      wen = w; waddr = wa; wdata = wd; ren = r; raddr = ra;
      @(posedge clk);
      #1;
      wen = 1'b0; ren = 1'b0;
      rdy0 = sram_rdy;
      stb0 = wb_stb;
      cyc  = 0;
      while (!sram_rdy && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!sram_rdy) begin
         ntests++; nfail++;
         $display("FAIL rdy_timeout: rdy=%0b after %0d cycles, required 1", sram_rdy, cyc);
      end
      stb_end = wb_stb;
      rd      = sram_rdata;
   endtask

   task automatic test_reset;
      rst = 1'b0; wen = 1'b0; ren = 1'b0; waddr = 8'h00; wdata = 8'h00; raddr = 8'h00;
      ack_force = 1'b0; wb_ack = 1'b0; wb_rdt = 32'h0;
      c_valid = 1'b0; c_tag = 6'h0;
      for (int i = 0; i < 64; i++) begin
         mem[i] = 32'h0; ref_mem[i] = 32'h0;
      end
      mem[0] = 32'hDDCCBBAA; ref_mem[0] = 32'hDDCCBBAA;
      mem[8] = 32'h44332211; ref_mem[8] = 32'h44332211;
      #1 rst = 1'b1;
      #2;
      ntests++;
      if (sram_rdy !== 1'b1 || wb_stb !== 1'b0) begin
         nfail++; $display("FAIL reset_rdy_stb: rdy=%b stb=%b, required 1 0", sram_rdy, wb_stb);
      end
      ntests++;
      if ({wb_we, wb_sel, wb_adr, wb_dat} !== 43'h0) begin
         nfail++; $display("FAIL reset_wb_outputs: we=%b sel=%h adr=%h dat=%h, required all 0", wb_we, wb_sel, wb_adr, wb_dat);
      end
      ntests++;
      if (sram_rdata !== 8'h00) begin
         nfail++; $display("FAIL reset_rdata: got %h, required 00", sram_rdata);
      end
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_write;
      int ec, cyc; logic rdy0, stb0, stbe; logic [7:0] rd; wb_t e, o;
      ack_lat = 0;
      model_req(1'b1, 8'h13, 8'hA5, 1'b0, 8'h00, ec);
      run_req(1'b1, 8'h13, 8'hA5, 1'b0, 8'h00, cyc, rdy0, stb0, stbe, rd);
      ntests++;
      if (rdy0 !== 1'b0 || stb0 !== 1'b1) begin
         nfail++; $display("FAIL write_busy: rdy=%b stb=%b after request, required 0 1", rdy0, stb0);
      end
      ntests++;
      if (cyc != ec || stbe !== 1'b0) begin
         nfail++; $display("FAIL write_timing: busy=%0d stb=%b at rdy, required %0d 0", cyc, stbe, ec);
      end
      while (exp_wb.size() > 0) begin
         e = exp_wb.pop_front(); ntests++;
         if (obs_wb.size() == 0) begin
            nfail++; $display("FAIL write_wb_missing: no cycle, required adr=%h sel=%h we=%b", e.adr, e.sel, e.we);
         end else begin
            o = obs_wb.pop_front();
            if (o.adr !== e.adr || o.sel !== e.sel || o.we !== e.we || o.dat !== e.dat) begin
               nfail++; $display("FAIL write_wb: got adr=%h sel=%h we=%b dat=%h, required adr=%h sel=%h we=%b dat=%h",
                                 o.adr, o.sel, o.we, o.dat, e.adr, e.sel, e.we, e.dat);
            end
         end
      end
      ntests++;
      if (obs_wb.size() != 0) begin
         nfail++; $display("FAIL write_wb_extra: got %0d extra cycles, required 0", obs_wb.size()); obs_wb.delete();
      end
   endtask

   task automatic test_read;
      int ec, cyc; logic rdy0, stb0, stbe; logic [7:0] rd, x; wb_t e, o;
      // miss with slow memory, then a follow-up read in the same word
      for (int k = 0; k < 2; k++) begin
         ack_lat = (k == 0) ? 3 : 0;
         model_req(1'b0, 8'h00, 8'h00, 1'b1, (k == 0) ? 8'h20 : 8'h22, ec);
         run_req(1'b0, 8'h00, 8'h00, 1'b1, (k == 0) ? 8'h20 : 8'h22, cyc, rdy0, stb0, stbe, rd);
         x = exp_rd.pop_front();
         ntests++;
         if (rd !== x) begin
            nfail++; $display("FAIL read%0d_rdata: got %h, required %h", k, rd, x);
         end
         ntests++;
         if (cyc != ec || rdy0 !== (ec == 0)) begin
            nfail++; $display("FAIL read%0d_timing: busy=%0d rdy=%b, required %0d %b", k, cyc, rdy0, ec, (ec == 0));
         end
         while (exp_wb.size() > 0) begin
            e = exp_wb.pop_front(); ntests++;
            if (obs_wb.size() == 0) begin
               nfail++; $display("FAIL read%0d_wb_missing: no cycle, required adr=%h", k, e.adr);
            end else begin
               o = obs_wb.pop_front();
               if (o.adr !== e.adr || o.sel !== e.sel || o.we !== e.we) begin
                  nfail++; $display("FAIL read%0d_wb: got adr=%h sel=%h we=%b, required adr=%h sel=%h we=%b",
                                    k, o.adr, o.sel, o.we, e.adr, e.sel, e.we);
               end
            end
         end
         ntests++;
         if (obs_wb.size() != 0) begin
            nfail++; $display("FAIL read%0d_wb_extra: got %0d extra cycles, required 0", k, obs_wb.size()); obs_wb.delete();
         end
      end
   endtask

   task automatic test_write_read;
      int ec, cyc; logic rdy0, stb0, stbe; logic [7:0] rd, x; wb_t e, o;
      ack_lat = 0;
      // simultaneous write+read of one byte, a write-only into the cached word
      // (rdata must hold), then a read back of that byte
      for (int k = 0; k < 3; k++) begin
         logic w, r; logic [7:0] a, d;
         w = (k != 2); r = (k != 1);
         a = (k == 0) ? 8'h21 : 8'h22;
         d = (k == 0) ? 8'h99 : 8'h77;
         model_req(w, a, d, r, a, ec);
         run_req(w, a, d, r, a, cyc, rdy0, stb0, stbe, rd);
         x = r ? exp_rd.pop_front() : 8'h99;
         ntests++;
         if (rd !== x) begin
            nfail++; $display("FAIL wr_rd%0d_rdata: got %h, required %h", k, rd, x);
         end
         ntests++;
         if (cyc != ec || stbe !== 1'b0) begin
            nfail++; $display("FAIL wr_rd%0d_timing: busy=%0d stb=%b, required %0d 0", k, cyc, stbe, ec);
         end
         while (exp_wb.size() > 0) begin
            e = exp_wb.pop_front(); ntests++;
            if (obs_wb.size() == 0) begin
               nfail++; $display("FAIL wr_rd%0d_wb_missing: no cycle, required adr=%h we=%b", k, e.adr, e.we);
            end else begin
               o = obs_wb.pop_front();
               if (o.adr !== e.adr || o.sel !== e.sel || o.we !== e.we || (e.we && o.dat !== e.dat)) begin
                  nfail++; $display("FAIL wr_rd%0d_wb: got adr=%h sel=%h we=%b dat=%h, required adr=%h sel=%h we=%b dat=%h",
                                    k, o.adr, o.sel, o.we, o.dat, e.adr, e.sel, e.we, e.dat);
               end
            end
         end
         ntests++;
         if (obs_wb.size() != 0) begin
            nfail++; $display("FAIL wr_rd%0d_wb_extra: got %0d extra cycles, required 0", k, obs_wb.size()); obs_wb.delete();
         end
      end
   endtask

   task automatic test_reset_midcycle;
      int ec, cyc; logic rdy0, stb0, stbe; logic [7:0] rd, x; wb_t e, o;
      ack_lat = 20;
      ren = 1'b1; raddr = 8'h20;
      @(posedge clk); #1;
      ren = 1'b0;
      ntests++;
      if (wb_stb !== 1'b1) begin
         nfail++; $display("FAIL midrst_stb_before: stb=%b, required 1", wb_stb);
      end
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      ntests++;
      if (wb_stb !== 1'b0 || sram_rdy !== 1'b1 || sram_rdata !== 8'h00) begin
         nfail++; $display("FAIL midrst_async: stb=%b rdy=%b rdata=%h, required 0 1 00", wb_stb, sram_rdy, sram_rdata);
      end
      @(posedge clk); #3;
      rst = 1'b0;
      c_valid = 1'b0;
      @(posedge clk); #1;
      ack_force = 1'b1;
      @(posedge clk); #1;
      ack_force = 1'b0;
      ntests++;
      if (wb_stb !== 1'b0 || sram_rdy !== 1'b1 || sram_rdata !== 8'h00 || obs_wb.size() != 0) begin
         nfail++; $display("FAIL midrst_stray_ack: stb=%b rdy=%b rdata=%h cycles=%0d, required 0 1 00 0",
                           wb_stb, sram_rdy, sram_rdata, obs_wb.size());
      end
      obs_wb.delete();
      ack_lat = 1;
      model_req(1'b0, 8'h00, 8'h00, 1'b1, 8'h20, ec);
      run_req(1'b0, 8'h00, 8'h00, 1'b1, 8'h20, cyc, rdy0, stb0, stbe, rd);
      x = exp_rd.pop_front();
      ntests++;
      if (rd !== x || cyc != ec) begin
         nfail++; $display("FAIL midrst_next_read: rdata=%h busy=%0d, required %h %0d", rd, cyc, x, ec);
      end
      while (exp_wb.size() > 0) begin
         e = exp_wb.pop_front(); ntests++;
         if (obs_wb.size() == 0) begin
            nfail++; $display("FAIL midrst_wb_missing: no cycle, required adr=%h", e.adr);
         end else begin
            o = obs_wb.pop_front();
            if (o.adr !== e.adr || o.sel !== e.sel || o.we !== e.we) begin
               nfail++; $display("FAIL midrst_wb: got adr=%h sel=%h we=%b, required adr=%h sel=%h we=%b",
                                 o.adr, o.sel, o.we, e.adr, e.sel, e.we);
            end
         end
      end
      ntests++;
      if (obs_wb.size() != 0) begin
         nfail++; $display("FAIL midrst_wb_extra: got %0d extra cycles, required 0", obs_wb.size()); obs_wb.delete();
      end
   endtask

   task automatic test_back_to_back;
      int ec, cyc; logic rdy0, stb0, stbe; logic [7:0] rd, x, a; wb_t e, o;
      ack_lat = 0;
      for (int k = 0; k < 4; k++) begin
         a = k[7:0];
         model_req(1'b0, 8'h00, 8'h00, 1'b1, a, ec);
         run_req(1'b0, 8'h00, 8'h00, 1'b1, a, cyc, rdy0, stb0, stbe, rd);
         x = exp_rd.pop_front();
         ntests++;
         if (rd !== x || cyc != ec) begin
            nfail++; $display("FAIL b2b%0d: rdata=%h busy=%0d, required %h %0d", k, rd, cyc, x, ec);
         end
      end
      while (exp_wb.size() > 0) begin
         e = exp_wb.pop_front(); ntests++;
         if (obs_wb.size() == 0) begin
            nfail++; $display("FAIL b2b_wb_missing: no cycle, required adr=%h", e.adr);
         end else begin
            o = obs_wb.pop_front();
            if (o.adr !== e.adr || o.sel !== e.sel || o.we !== e.we) begin
               nfail++; $display("FAIL b2b_wb: got adr=%h sel=%h we=%b, required adr=%h sel=%h we=%b",
                                 o.adr, o.sel, o.we, e.adr, e.sel, e.we);
            end
         end
      end
      ntests++;
      if (obs_wb.size() != 0) begin
         nfail++; $display("FAIL b2b_wb_extra: got %0d extra cycles, required 0", obs_wb.size()); obs_wb.delete();
      end
   endtask

   initial begin
      test_reset;
      test_write;
      test_read;
      test_write_read;
      test_reset_midcycle;
      test_back_to_back;
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench still running at %0t, required completion", $time);
      $fatal(1);
   end

endmodule
